regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 130 +++++++++++++
 tb/tb_regfile_writeback.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file writeback queue: 4-entry FIFO drained one entry per cycle, with hazard lookup.
// Optional macro WB_BYPASS_EN forwards the youngest pending data for query_r on query_data.
module regfile_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_rd,
  input  logic [23:0] req_data,
  output logic [2:0]  Rw,
  output logic [23:0] BusW,
  output logic        enWrite,
  input  logic [2:0]  query_r,
  output logic        query_hit,
  output logic [23:0] query_data,
  output logic [2:0]  pending_cnt,
  output logic [7:0]  drop_cnt
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  rd_mem   [4];
  logic [23:0] data_mem [4];
  logic [1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [2:0]  cnt_reg;
  logic [7:0]  drop_reg;
  logic [2:0]  rw_reg;
  logic [23:0] busw_reg;
  logic        en_reg;
  logic        push, pop;
  logic [3:0]  slot_match;
  logic        out_match;

  assign req_ready   = !rst && (cnt_reg < 3'd4);
  assign push        = req_valid && req_ready;
  assign pending_cnt = cnt_reg;
  assign drop_cnt    = drop_reg;
  assign Rw          = rw_reg;
  assign BusW        = busw_reg;
  assign enWrite     = en_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (push) state_next = DRAIN;
      DRAIN: if (cnt_reg == 3'd1 && !push) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // DRAIN guarantees a non-empty queue, so popping every DRAIN cycle is safe.
  always_comb begin
    pop = 1'b0;
    if (state_reg == DRAIN) pop = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= req_rd;
      data_mem[wr_ptr_reg] <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      drop_reg   <= '0;
      rw_reg     <= '0;
      busw_reg   <= '0;
      en_reg     <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      cnt_reg <= cnt_reg + {2'b00, push} - {2'b00, pop};
      en_reg  <= 1'b0;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 2'd1;
        rw_reg     <= rd_mem[rd_ptr_reg];
        busw_reg   <= data_mem[rd_ptr_reg];
        en_reg     <= (rd_mem[rd_ptr_reg] != 3'd0);
        if (rd_mem[rd_ptr_reg] == 3'd0 && drop_reg != 8'hFF)
          drop_reg <= drop_reg + 8'd1;
      end
    end
  end

  // Slot gi is the gi-th oldest queued entry; only the first cnt_reg slots are live.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic [1:0] idx;
      assign idx            = rd_ptr_reg + 2'(gi);
      assign slot_match[gi] = (3'(gi) < cnt_reg) && (rd_mem[idx] == query_r);
    end
  endgenerate

  assign out_match = en_reg && (rw_reg == query_r);
  assign query_hit = (query_r != 3'd0) && (out_match || (|slot_match));

`ifdef WB_BYPASS_EN
  logic [23:0] slot_data [4];
  logic [23:0] fwd_data;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_fwd
      assign slot_data[gi] = data_mem[rd_ptr_reg + 2'(gi)];
    end
  endgenerate

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_data = '0;
    if (out_match) fwd_data = busw_reg;
    for (int k = 0; k < 4; k++)
      if (slot_match[k]) fwd_data = slot_data[k];
  end

  assign query_data = query_hit ? fwd_data : 24'h000000;
`else
  assign query_data = 24'h000000;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback; inputs change at negedge,
// outputs are sampled 1ns after the rising edge.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_rd;
  logic [23:0] req_data;
  logic [2:0]  Rw;
  logic [23:0] BusW;
  logic        enWrite;
  logic [2:0]  query_r;
  logic        query_hit;
  logic [23:0] query_data;
  logic [2:0]  pending_cnt;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;
  int max_pend;
  int pulses;

  regfile_writeback dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .Rw(Rw), .BusW(BusW), .enWrite(enWrite),
    .query_r(query_r), .query_hit(query_hit), .query_data(query_data),
    .pending_cnt(pending_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance through one rising edge and settle; next input change lands after negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] rd, input logic [23:0] d);
    @(negedge clk);
    req_valid = v;
    req_rd    = rd;
    req_data  = d;
  endtask

  localparam logic [23:0] EXP_BYP = 
`ifdef WB_BYPASS_EN
    24'h000020;
`else
    24'h000000;
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rd = '0; req_data = '0; query_r = '0;
    tick(); tick();
    check("rst_ready",   32'(req_ready), 0);
    check("rst_pending", 32'(pending_cnt), 0);
    check("rst_en",      32'(enWrite), 0);
    check("rst_drop",    32'(drop_cnt), 0);
    check("rst_rw",      32'(Rw), 0);
    check("rst_busw",    32'(BusW), 0);
    @(negedge clk); rst = 1'b0; #1;
    check("ready_after_rst", 32'(req_ready), 1);

    // Single write: latency of one cycle, then a single pulse.
    drive(1'b1, 3'd3, 24'h00ABCD); tick();
    check("single_pend1", 32'(pending_cnt), 1);
    check("single_en_c1", 32'(enWrite), 0);
    drive(1'b0, 3'd0, 24'h0); tick();
    check("single_en",   32'(enWrite), 1);
    check("single_rw",   32'(Rw), 3);
    check("single_busw", 32'(BusW), 32'h00ABCD);
    check("single_pend0", 32'(pending_cnt), 0);
    tick();
    check("single_en_off", 32'(enWrite), 0);
    check("single_rw_hold", 32'(Rw), 3);
    check("single_busw_hold", 32'(BusW), 32'h00ABCD);

    // Back-to-back six requests: ready stays high, one pulse per cycle, in order.
    max_pend = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'(i + 1), 24'h000100 + 24'(i));
      #1;
      check($sformatf("b2b_ready%0d", i), 32'(req_ready), 1);
      tick();
      if (int'(pending_cnt) > max_pend) max_pend = int'(pending_cnt);
      if (i > 0) begin
        check($sformatf("b2b_en%0d", i),   32'(enWrite), 1);
        check($sformatf("b2b_rw%0d", i),   32'(Rw), 32'(i));
        check($sformatf("b2b_busw%0d", i), 32'(BusW), 32'h100 + 32'(i - 1));
      end
    end
    drive(1'b0, 3'd0, 24'h0); tick();
    check("b2b_en6",   32'(enWrite), 1);
    check("b2b_rw6",   32'(Rw), 6);
    check("b2b_busw6", 32'(BusW), 32'h105);
    check("b2b_maxpend", 32'(max_pend), 1);
    tick();
    check("b2b_en_off", 32'(enWrite), 0);

    // R0 writes are discarded and counted; query of R0 never hits.
    drive(1'b1, 3'd0, 24'h123456); tick();
    query_r = 3'd0; #1;
    check("r0_qhit_queued", 32'(query_hit), 0);
    drive(1'b0, 3'd0, 24'h0); tick();
    check("r0_en",   32'(enWrite), 0);
    check("r0_drop", 32'(drop_cnt), 1);
    check("r0_qhit", 32'(query_hit), 0);

    // Hazard: two writes to r5; youngest pending data is forwarded.
    drive(1'b1, 3'd5, 24'h000010); tick();
    query_r = 3'd5; #1;
    check("haz_hit_q1", 32'(query_hit), 1);
    drive(1'b1, 3'd5, 24'h000020); tick();
    check("haz_en",   32'(enWrite), 1);
    check("haz_busw", 32'(BusW), 32'h10);
    check("haz_hit",  32'(query_hit), 1);
    check("haz_data", 32'(query_data), 32'(EXP_BYP));
    query_r = 3'd4; #1;
    check("haz_miss", 32'(query_hit), 0);
    check("haz_miss_data", 32'(query_data), 0);
    query_r = 3'd5;
    drive(1'b0, 3'd0, 24'h0); tick();
    check("haz_out_hit",  32'(query_hit), 1);
    check("haz_out_data", 32'(query_data), 32'(EXP_BYP));
    tick();
    check("haz_clear", 32'(query_hit), 0);

    // Reset in the middle of a drain.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd2, 24'h000300 + 24'(i)); tick();
    end
    @(negedge clk); rst = 1'b1; #1;
    check("mid_rst_ready", 32'(req_ready), 0);
    tick();
    check("mid_rst_pend", 32'(pending_cnt), 0);
    check("mid_rst_en",   32'(enWrite), 0);
    check("mid_rst_drop", 32'(drop_cnt), 0);
    @(negedge clk); rst = 1'b0; req_valid = 1'b0; #1;
    check("mid_rst_ready_after", 32'(req_ready), 1);
    tick();
    check("mid_rst_en_after", 32'(enWrite), 0);
    check("mid_rst_pend_after", 32'(pending_cnt), 0);

    // drop_cnt saturates at 255.
    pulses = 0;
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 3'd0, 24'(i)); tick();
      if (enWrite) pulses++;
    end
    drive(1'b0, 3'd0, 24'h0); tick();
    if (enWrite) pulses++;
    tick();
    check("sat_drop",   32'(drop_cnt), 255);
    check("sat_pulses", 32'(pulses), 0);
    check("sat_pend",   32'(pending_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
